data_mem_responder: RTL

//  Memory-side responder for the core's load/store requests (LW/LH/LB/LHU/LBU/SW/SH/SB).

---
 rtl/data_mem_responder_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 79 +++++++
 rtl/data_mem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder.
//   load_store_func_code : load/store function encoding on req_func
//   dmem_state_e         : responder FSM state
//   dmem_req_t           : latched request payload (addr/func/wdata)
package data_mem_responder_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FUNC_W    = 3;
    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic [FUNC_W-1:0] {
        LS_LW  = 3'd0,
        LS_LH  = 3'd1,
        LS_LB  = 3'd2,
        LS_LHU = 3'd3,
        LS_LBU = 3'd4,
        LS_SW  = 3'd5,
        LS_SH  = 3'd6,
        LS_SB  = 3'd7
    } load_store_func_code;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        load_store_func_code func;
        logic [DATA_W-1:0]   wdata;
    } dmem_req_t;

    function automatic logic is_store(input load_store_func_code f);
        return (f == LS_SW) || (f == LS_SH) || (f == LS_SB);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory responder (purely combinational).
//   func_i       : load/store function
//   addr_i       : byte offset within the word
//   wdata_i      : right-aligned store data
//   raw_word_i   : word currently held in RAM at the target index
//   byte_en_o    : lanes written by a store (0 for loads)
//   store_word_o : store data replicated across lanes
//   load_word_o  : selected and extended load result
//   misalign_o   : access not naturally aligned for its size
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  load_store_func_code func_i,
    input  logic [1:0]          addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]   raw_word_i,
    output logic [3:0]          byte_en_o,
    output logic [DATA_W-1:0]   store_word_o,
    output logic [DATA_W-1:0]   load_word_o,
    output logic                misalign_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane pick for sub-word loads
    always_comb begin
        sel_byte = raw_word_i[7:0];
        case (addr_i)
            2'd0:    sel_byte = raw_word_i[7:0];
            2'd1:    sel_byte = raw_word_i[15:8];
            2'd2:    sel_byte = raw_word_i[23:16];
            default: sel_byte = raw_word_i[31:24];
        endcase
        sel_half = addr_i[1] ? raw_word_i[31:16] : raw_word_i[15:0];
    end

    // Per-function enables, replication, extension and alignment check
    always_comb begin
        byte_en_o    = 4'b0000;
        store_word_o = '0;
        load_word_o  = '0;
        misalign_o   = 1'b0;
        case (func_i)
            LS_LW: begin
                misalign_o  = (addr_i != 2'd0);
                load_word_o = raw_word_i;
            end
            LS_LH: begin
                misalign_o  = addr_i[0];
                load_word_o = {{16{sel_half[15]}}, sel_half};
            end
            LS_LHU: begin
                misalign_o  = addr_i[0];
                load_word_o = {16'h0000, sel_half};
            end
            LS_LB:  load_word_o = {{24{sel_byte[7]}}, sel_byte};
            LS_LBU: load_word_o = {24'h000000, sel_byte};
            LS_SW: begin
                misalign_o   = (addr_i != 2'd0);
                byte_en_o    = 4'b1111;
                store_word_o = wdata_i;
            end
            LS_SH: begin
                misalign_o   = addr_i[0];
                byte_en_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                store_word_o = {2{wdata_i[15:0]}};
            end
            LS_SB: begin
                byte_en_o    = 4'b0001 << addr_i;
                store_word_o = {4{wdata_i[7:0]}};
            end
            default: begin
                byte_en_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for core load/store requests with programmable latency.
//   clk, rst                        : clock, async active-high reset
//   req_valid/req_ready             : request handshake (ready only in DM_IDLE, rst low)
//   req_addr, req_func, req_wdata   : byte address, function, right-aligned store data
//   rsp_valid/rsp_ready             : response handshake, response held until consumed
//   rsp_rdata, rsp_err              : extended load data (0 for stores/errors), error flag
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [FUNC_W-1:0] req_func,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_e             state_q;
    logic [LAT_CNT_W-1:0]    cnt_q;
    dmem_req_t               req_q;
    logic                    rsp_valid_q;
    logic [DATA_W-1:0]       rsp_rdata_q;
    logic                    rsp_err_q;
    logic [DATA_W-1:0]       mem_q [DEPTH_WORDS];

    dmem_req_t               req_in_c;
    dmem_req_t               cur_c;
    logic [IDX_W-1:0]        idx_c;
    logic                    oor_c;
    logic                    misalign_c;
    logic                    err_c;
    logic                    store_c;
    logic                    accept_c;
    logic                    enter_resp_c;
    logic                    mem_we_c;
    logic [3:0]              byte_en_c;
    logic [DATA_W-1:0]       store_word_c;
    logic [DATA_W-1:0]       load_word_c;
    logic [DATA_W-1:0]       raw_word_c;
    logic [DATA_W-1:0]       rsp_rdata_d;

    assign req_ready = (state_q == DM_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign accept_c = req_valid && req_ready;

    // With zero latency the RAM is accessed on the accept edge itself, so the
    // datapath sees the live request in DM_IDLE and the latched one otherwise.
    assign req_in_c = '{addr: req_addr, func: load_store_func_code'(req_func), wdata: req_wdata};
    assign cur_c    = (state_q == DM_IDLE) ? req_in_c : req_q;

    assign idx_c      = cur_c.addr[IDX_W+1:2];
    assign oor_c      = (cur_c.addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));
    assign raw_word_c = mem_q[idx_c];
    assign store_c    = is_store(cur_c.func);
    assign err_c      = misalign_c || oor_c;

    mem_lane_align u_align (
        .func_i       (cur_c.func),
        .addr_i       (cur_c.addr[1:0]),
        .wdata_i      (cur_c.wdata),
        .raw_word_i   (raw_word_c),
        .byte_en_o    (byte_en_c),
        .store_word_o (store_word_c),
        .load_word_o  (load_word_c),
        .misalign_o   (misalign_c)
    );

    assign enter_resp_c = ((state_q == DM_IDLE) && accept_c && (LATENCY == 0)) ||
                          ((state_q == DM_WAIT) && (cnt_q == '0));
    assign mem_we_c     = enter_resp_c && store_c && !err_c;
    assign rsp_rdata_d  = (err_c || store_c) ? '0 : load_word_c;

    // Responder FSM, wait counter, request latch and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DM_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                DM_IDLE: begin
                    if (accept_c) begin
                        req_q <= req_in_c;
                        if (LATENCY == 0) begin
                            state_q <= DM_RESP;
                        end else begin
                            state_q <= DM_WAIT;
                            cnt_q   <= LAT_CNT_W'(LATENCY - 1);
                        end
                    end
                end
                DM_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= DM_RESP;
                    end else begin
                        cnt_q <= cnt_q - LAT_CNT_W'(1);
                    end
                end
                DM_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= DM_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= DM_IDLE;
            endcase

            if (enter_resp_c) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= err_c;
            end
        end
    end

    // Byte-enable RAM write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= store_word_c[8*b +: 8];
                end
            end
        end
    end

endmodule
